// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, arbiter FSM states and carry-op helper shared by the ALU arbiter.
// Contents: OP_AND..OP_SLL (0..10), OP_MAX, arb_state_t {IDLE, EXEC, RESP}, op_has_carry().
package alu_pkg;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_NOR = 3;
    localparam int OP_ADD = 4;
    localparam int OP_SUB = 5;
    localparam int OP_SLT = 6;
    localparam int OP_BEQ = 7;
    localparam int OP_SRL = 8;
    localparam int OP_SRA = 9;
    localparam int OP_SLL = 10;
    localparam int OP_MAX = 10;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

    // Only adds, subtracts and shifts have a meaningful carry/shift-out.
    function automatic logic op_has_carry(input int op);
        return op inside {OP_ADD, OP_SUB, OP_SRL, OP_SRA, OP_SLL};
    endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational one-hot requester picker.
// Ports: valid (requests), last (previous winner, only with ALU_ARB_RR_EN), en (grant allowed),
//        grant (one-hot, subset of valid, zero when en is low).
// Macro ALU_ARB_RR_EN: round-robin starting after last; otherwise a fixed lowest-index priority encoder.
module alu_arb_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         valid,
`ifdef ALU_ARB_RR_EN
    input  logic [$clog2(NUM_REQ)-1:0] last,
`endif
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant
);

`ifdef ALU_ARB_RR_EN
    // Walk the offsets last+1 .. last+NUM_REQ; the first valid requester found wins.
    always_comb begin
        grant = '0;
        for (int k = 1; k <= NUM_REQ; k++)
            for (int i = 0; i < NUM_REQ; i++)
                if (en && grant == '0 && valid[i] && i == (int'(last) + k) % NUM_REQ)
                    grant[i] = 1'b1;
    end
`else
    // Scan from the top so the lowest valid index is the one left standing.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (en && valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters with a registered grant,
// a one-cycle ALU execute slot and a held, sanitised, requester-tagged response.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_ra/req_rb/req_op (requesters);
//        alu_ra/alu_rb/alu_op -> ALU, alu_res/alu_car/alu_zero/alu_branch <- ALU;
//        rsp_valid/rsp_ready/rsp_id/rsp_res/rsp_car/rsp_zero/rsp_branch/rsp_err (response).
// Macro ALU_ARB_RR_EN: round-robin arbitration; undefined gives fixed lowest-index priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 4,
    parameter int NUM_REQ   = 3,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_ra,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0] req_rb,
    input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]  req_op,
    output logic [REG_WIDTH-1:0]              alu_ra,
    output logic [REG_WIDTH-1:0]              alu_rb,
    output logic [OP_WIDTH-1:0]               alu_op,
    input  logic [REG_WIDTH-1:0]              alu_res,
    input  logic [REG_WIDTH-1:0]              alu_car,
    input  logic                              alu_zero,
    input  logic                              alu_branch,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_WIDTH-1:0]               rsp_id,
    output logic [REG_WIDTH-1:0]              rsp_res,
    output logic [REG_WIDTH-1:0]              rsp_car,
    output logic                              rsp_zero,
    output logic                              rsp_branch,
    output logic                              rsp_err
);

    arb_state_t           state, state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic                 pick_en, xfer;
    logic [ID_WIDTH-1:0]  gnt_id, cur_id;
    logic [REG_WIDTH-1:0] sel_ra, sel_rb, san_res, san_car;
    logic [OP_WIDTH-1:0]  sel_op;
    logic                 san_zero, san_branch, san_err;
    logic                 unused_alu_zero;

    // The zero flag is recomputed from the sanitised result, so the ALU's own flag is not needed.
    assign unused_alu_zero = alu_zero;

    // Grants are allowed when idle, or while the held response is drained this same cycle.
    assign pick_en = rst_n && (state == IDLE || (state == RESP && rsp_ready));

`ifdef ALU_ARB_RR_EN
    logic [ID_WIDTH-1:0] last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= ID_WIDTH'(NUM_REQ - 1);
        else if (xfer)
            last <= gnt_id;
`endif

    alu_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid(req_valid),
`ifdef ALU_ARB_RR_EN
        .last (last),
`endif
        .en   (pick_en),
        .grant(grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        gnt_id = '0;
        sel_ra = '0;
        sel_rb = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                gnt_id = ID_WIDTH'(i);
                sel_ra = req_ra[i];
                sel_rb = req_rb[i];
                sel_op = req_op[i];
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;

    // IDLE and a draining RESP both leave on a grant; an undrained RESP holds.
    always_comb
        state_nxt = (state == EXEC) ? RESP :
                    (state == IDLE || rsp_ready) ? (xfer ? EXEC : IDLE) : RESP;

    always_comb
        rsp_valid = (state == RESP);

    // ALU inputs only move on a grant, so they stay frozen outside the execute slot.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_ra <= '0;
            alu_rb <= '0;
            alu_op <= '0;
            cur_id <= '0;
        end else if (xfer) begin
            alu_ra <= sel_ra;
            alu_rb <= sel_rb;
            alu_op <= sel_op;
            cur_id <= gnt_id;
        end

    always_comb begin
        san_err    = int'(alu_op) > OP_MAX;
        san_res    = (san_err || int'(alu_op) == OP_BEQ) ? '0 : alu_res;
        san_car    = op_has_carry(int'(alu_op)) ? alu_car : '0;
        san_branch = int'(alu_op) == OP_BEQ && alu_branch;
        san_zero   = san_res == '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_id     <= '0;
            rsp_res    <= '0;
            rsp_car    <= '0;
            rsp_zero   <= 1'b0;
            rsp_branch <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id     <= cur_id;
            rsp_res    <= san_res;
            rsp_car    <= san_car;
            rsp_zero   <= san_zero;
            rsp_branch <= san_branch;
            rsp_err    <= san_err;
        end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a stand-in ALU and a transaction-level model.
module tb_alu_arbiter;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0, req_ready;
    logic [N-1:0][7:0]   req_ra = '0, req_rb = '0;
    logic [N-1:0][3:0]   req_op = '0;
    logic [7:0]          alu_ra, alu_rb, alu_res, alu_car, t_res, t_car;
    logic [3:0]          alu_op;
    logic                alu_zero, alu_branch;
    logic                rsp_valid, rsp_ready = 1'b0;
    logic [1:0]          rsp_id;
    logic [7:0]          rsp_res, rsp_car;
    logic                rsp_zero, rsp_branch, rsp_err;
    int                  checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.REG_WIDTH(8), .OP_WIDTH(4), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .req_op(req_op),
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
        .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_zero(rsp_zero),
        .rsp_branch(rsp_branch), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] car;
        logic       zero;
        logic       br;
        logic       err;
        logic [1:0] id;
    } rsp_t;

    // Plain arithmetic meaning of each opcode: result and carry/shift-out.
    function automatic void math(input int op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [7:0] c);
        logic [8:0]  s;
        logic [15:0] w;
        int          sh;
        sh = int'(b[2:0]);
        r = '0;
        c = '0;
        w = '0;
        s = '0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~(a | b);
            4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = {7'b0, s[8]}; end
            5: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = {7'b0, s[8]}; end
            6: r = {7'b0, a < b};
            8: begin w = {a, 8'b0} >> sh; r = w[15:8]; c = w[7:0]; end
            9: begin w = 16'($signed({a, 8'b0}) >>> sh); r = w[15:8]; c = w[7:0]; end
            10: begin w = {8'b0, a} << sh; r = w[7:0]; c = w[15:8]; end
            default: ;
        endcase
    endfunction

    // Stand-in ALU: correct where it matters, deliberate junk wherever the arbiter must mask it.
    always_comb begin
        math(int'(alu_op), alu_ra, alu_rb, t_res, t_car);
        alu_res    = (alu_op == 4'd7 || alu_op > 4'd10) ? (alu_ra ^ alu_rb ^ 8'hA5) : t_res;
        alu_car    = (int'(alu_op) inside {4, 5, 8, 9, 10}) ? t_car : ~alu_ra;
        alu_branch = (alu_op == 4'd7) ? (alu_ra == alu_rb) : (alu_ra[0] ^ alu_rb[1]);
        alu_zero   = alu_res == '0;
    end

    // The response a consumer should see for an operation, straight from the rules.
    function automatic rsp_t expect_rsp(input int op, input logic [7:0] a, input logic [7:0] b, input int id);
        rsp_t       e;
        logic [7:0] r, c;
        math(op, a, b, r, c);
        e.err  = op > 10;
        e.br   = op == 7 && a == b;
        e.res  = (op > 10 || op == 7) ? 8'h00 : r;
        e.car  = (op inside {4, 5, 8, 9, 10}) ? c : 8'h00;
        e.zero = e.res == 8'h00;
        e.id   = 2'(id);
        return e;
    endfunction

    // Model: phase counts progress of the single in-flight op (0 none, 1 computing, 2 answer waiting).
    int         m_phase, m_last, m_op, m_id;
    logic [7:0] m_ra, m_rb;
    rsp_t       m_rsp;

    task automatic model_reset();
        m_phase = 0;
        m_last  = N - 1;
        m_op    = 0;
        m_id    = 0;
        m_ra    = '0;
        m_rb    = '0;
        m_rsp   = '0;
    endtask

    function automatic int pick_exp();
        if (!rst_n || !(m_phase == 0 || (m_phase == 2 && rsp_ready)))
            return -1;
`ifdef ALU_ARB_RR_EN
        for (int k = 1; k <= N; k++)
            if (req_valid[(m_last + k) % N])
                return (m_last + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (req_valid[i])
                return i;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0)
            v[g] = 1'b1;
        return v;
    endfunction

    // Advance the model across one rising edge, then move the bench to the next falling edge.
    task automatic tick();
        int g;
        g = pick_exp();
        if (m_phase == 1) begin
            m_rsp   = expect_rsp(m_op, m_ra, m_rb, m_id);
            m_phase = 2;
        end else if (m_phase == 2 && rsp_ready)
            m_phase = 0;
        if (g >= 0) begin
            m_ra    = req_ra[g];
            m_rb    = req_rb[g];
            m_op    = int'(req_op[g]);
            m_id    = g;
            m_last  = g;
            m_phase = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
    endtask

    // Issue one op from requester id while idle and stop at the first cycle its response is held.
    task automatic run_op(input int id, input int op, input logic [7:0] a, input logic [7:0] b);
        req_valid     = onehot(id);
        req_op[id]    = 4'(op);
        req_ra[id]    = a;
        req_rb[id]    = b;
        rsp_ready     = 1'b1;
        tick();
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rsp_valid)
                break;
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_op_timeout op=%0d rsp_valid=%b exp=1", op, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        req_valid = 3'b111;
        req_op    = {4'd5, 4'd9, 4'd2};
        #1;
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if ({rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id} !== 21'd0) begin
            errors++; $display("FAIL reset_rsp_fields got=%h exp=0", {rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id});
        end
        checks++;
        if ({alu_ra, alu_rb, alu_op} !== 20'd0) begin
            errors++; $display("FAIL reset_alu got=%h exp=0", {alu_ra, alu_rb, alu_op});
        end
        repeat (2) @(negedge clk);
        req_valid = 3'b001;
        req_op[0] = 4'd4;
        req_ra[0] = 8'hF0;
        req_rb[0] = 8'h20;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL first_grant got=%b exp=001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if ({alu_ra, alu_rb, alu_op, rsp_valid} !== {8'hF0, 8'h20, 4'd4, 1'b0}) begin
            errors++; $display("FAIL first_exec got=%h exp=%h", {alu_ra, alu_rb, alu_op, rsp_valid}, {8'hF0, 8'h20, 4'd4, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({rsp_valid, rsp_res, rsp_car, rsp_id} !== {1'b1, 8'h10, 8'h01, 2'd0}) begin
            errors++; $display("FAIL first_rsp got=%h exp=%h", {rsp_valid, rsp_res, rsp_car, rsp_id}, {1'b1, 8'h10, 8'h01, 2'd0});
        end
        drain();
    endtask

    task automatic test_round_robin();
        int seq[4];
`ifdef ALU_ARB_RR_EN
        seq = '{0, 1, 2, 0};
`else
        seq = '{0, 0, 0, 0};
`endif
        do_reset();
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_op[i] = 4'($urandom_range(0, 10));
            req_ra[i] = 8'($urandom);
            req_rb[i] = 8'($urandom);
        end
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] exp;
            exp = (c % 2 == 1) ? '0 : onehot(seq[c / 2]);
            #1;
            checks++;
            if (req_ready !== exp) begin errors++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, exp); end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_next;
`ifdef ALU_ARB_RR_EN
        exp_next = 3'b100;
`else
        exp_next = 3'b001;
`endif
        do_reset();
        req_valid = 3'b010;
        req_op[1] = 4'd5;
        req_ra[1] = 8'h10;
        req_rb[1] = 8'h20;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
        req_valid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b exp=000", c, req_ready); end
            checks++;
            if ({rsp_valid, rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id} !== {1'b1, 8'hF0, 8'h01, 1'b0, 1'b0, 1'b0, 2'd1}) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", c,
                    {rsp_valid, rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id},
                    {1'b1, 8'hF0, 8'h01, 1'b0, 1'b0, 1'b0, 2'd1});
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b1, exp_next}) begin
            errors++; $display("FAIL bp_release got=%b exp=%b", {rsp_valid, req_ready}, {1'b1, exp_next});
        end
        tick();
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", rsp_valid); end
        drain();
    endtask

    task automatic test_beq();
        run_op(0, 7, 8'h55, 8'h55);
        checks++;
        if ({rsp_branch, rsp_res, rsp_zero, rsp_car, rsp_err} !== {1'b1, 8'h00, 1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL beq_taken got=%h exp=%h", {rsp_branch, rsp_res, rsp_zero, rsp_car, rsp_err}, {1'b1, 8'h00, 1'b1, 8'h00, 1'b0});
        end
        drain();
        run_op(1, 7, 8'h55, 8'h54);
        checks++;
        if ({rsp_branch, rsp_res, rsp_zero, rsp_id} !== {1'b0, 8'h00, 1'b1, 2'd1}) begin
            errors++; $display("FAIL beq_not_taken got=%h exp=%h", {rsp_branch, rsp_res, rsp_zero, rsp_id}, {1'b0, 8'h00, 1'b1, 2'd1});
        end
        drain();
    endtask

    task automatic test_illegal();
        run_op(2, 12, 8'h33, 8'h44);
        checks++;
        if ({rsp_err, rsp_res, rsp_zero, rsp_car, rsp_branch, rsp_id} !== {1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 2'd2}) begin
            errors++; $display("FAIL illegal_op got=%h exp=%h", {rsp_err, rsp_res, rsp_zero, rsp_car, rsp_branch, rsp_id}, {1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 2'd2});
        end
        drain();
        run_op(0, 0, 8'h0F, 8'h3C);
        checks++;
        if ({rsp_err, rsp_res, rsp_zero, rsp_car} !== {1'b0, 8'h0C, 1'b0, 8'h00}) begin
            errors++; $display("FAIL after_illegal got=%h exp=%h", {rsp_err, rsp_res, rsp_zero, rsp_car}, {1'b0, 8'h0C, 1'b0, 8'h00});
        end
        drain();
    endtask

    task automatic test_mid_exec_reset();
        do_reset();
        req_valid = 3'b010;
        req_op[1] = 4'd1;
        req_ra[1] = 8'h81;
        req_rb[1] = 8'h18;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({rsp_valid, alu_ra, alu_rb, alu_op} !== 21'd0) begin
            errors++; $display("FAIL mid_reset_async got=%h exp=0", {rsp_valid, alu_ra, alu_rb, alu_op});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp cycle=%0d got=%b exp=0", c, rsp_valid); end
            tick();
        end
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL mid_reset_regrant got=%b exp=001", req_ready); end
        tick();
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] exp;
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_op[i] = 4'($urandom);
                req_ra[i] = 8'($urandom);
                req_rb[i] = 8'($urandom);
            end
            exp = onehot(pick_exp());
            #1;
            checks++;
            if (req_ready !== exp) begin errors++; $display("FAIL rand_grant cycle=%0d got=%b exp=%b", c, req_ready, exp); end
            checks++;
            if (rsp_valid !== (m_phase == 2)) begin errors++; $display("FAIL rand_valid cycle=%0d got=%b exp=%b", c, rsp_valid, m_phase == 2); end
            checks++;
            if ({alu_ra, alu_rb, alu_op} !== {m_ra, m_rb, 4'(m_op)}) begin
                errors++; $display("FAIL rand_alu cycle=%0d got=%h exp=%h", c, {alu_ra, alu_rb, alu_op}, {m_ra, m_rb, 4'(m_op)});
            end
            if (m_phase == 2) begin
                checks++;
                if ({rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id} !== m_rsp) begin
                    errors++; $display("FAIL rand_rsp cycle=%0d got=%h exp=%h", c, {rsp_res, rsp_car, rsp_zero, rsp_branch, rsp_err, rsp_id}, m_rsp);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_beq();
        test_illegal();
        test_mid_exec_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` among `NUM_REQ` requesters (e.g. fetch/branch unit, load/store address unit, execute) via per-requester valid/ready handshakes. A grant is registered, the operands are driven to the ALU for one cycle, and the sanitised ALU outputs are held in a response register until consumed. The block sits between the requesters and the `alu` instance. The response is tagged with the requester index.

## Interface
Parameters:
- `REG_WIDTH`, 8, operand/result width
- `OP_WIDTH`, 4, ALU opcode width
- `NUM_REQ`, 3, number of requesters (2..4)
- `ID_WIDTH`, `$clog2(NUM_REQ)`, width of the requester tag

Ports:
- `clk`  in  1  the only clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid`  in  NUM_REQ  per-requester request
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `req_ra`, `req_rb`  in  NUM_REQ×REG_WIDTH  operands per requester
- `req_op`  in  NUM_REQ×OP_WIDTH  opcode per requester
- `alu_ra`, `alu_rb`  out  REG_WIDTH  operands to the ALU
- `alu_op`  out  OP_WIDTH  opcode to the ALU
- `alu_res`, `alu_car`  in  REG_WIDTH  ALU result and carry/shift-out
- `alu_zero`, `alu_branch`  in  1  ALU flags
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  ID_WIDTH  index of the requester that owns the response
- `rsp_res`, `rsp_car`  out  REG_WIDTH  result and carry
- `rsp_zero`, `rsp_branch`, `rsp_err`  out  1  zero flag, branch-taken flag, illegal-opcode flag

## Operation
- FSM states:
  - IDLE: `req_ready` may assert.
  - EXEC: the latched operands and opcode drive `alu_*`, and the ALU outputs are captured into the response register at the end of the cycle.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE→EXEC on any transfer.
  - EXEC→RESP always.
  - RESP→IDLE on `rsp_ready` when no transfer occurs that cycle.
  - RESP→EXEC on `rsp_ready` when a transfer occurs that cycle.
- `req_ready` asserts only in IDLE, or in RESP when `rsp_ready`=1. At most one bit is set, and only for a requester with `req_valid`=1.
- Round-robin arbitration: the search starts at `last+1` mod NUM_REQ, where `last` is the index of the last granted requester. `last` updates only on a transfer.
- Outside EXEC, `alu_ra`/`alu_rb`/`alu_op` hold their last values. This avoids toggling the ALU inputs.
- Response sanitising rules:
  - `rsp_car` = `alu_car` for ops 4, 5, 8, 9, 10; 0 otherwise.
  - `rsp_branch` = `alu_branch` for op 7 only.
  - `rsp_res` = 0 for op 7.
  - `rsp_zero` = (`rsp_res`==0).
- Ops 11–15 are accepted: response `rsp_err`=1, `rsp_res`=0, `rsp_car`=0, `rsp_zero`=1, `rsp_branch`=0.

## Timing
- Latency: transfer in cycle N, EXEC in cycle N+1, `rsp_valid` in cycle N+2.
- With `rsp_ready` held at 1 and requests always pending, throughput is one operation per 2 cycles.
- Response fields are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset (asynchronous assert, synchronous-style deassert at the next clock edge):
  - state=IDLE
  - `req_ready`=0, `rsp_valid`=0
  - all `rsp_*` and `alu_*` outputs = 0
  - `last`=NUM_REQ-1, so requester 0 wins first
- Reset asserted mid-EXEC or mid-RESP discards the operation with no response.
- A `req_valid` dropped before grant is legal: that requester is skipped.
- Simultaneous `rsp_ready` and new requests in RESP: the new grant and the response drain happen in the same cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority. The lowest index always wins, and `last` is not implemented.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_AND`..`OP_SLL` (0..10) and `OP_MAX`=10
  - the FSM enum `arb_state_t` {IDLE, EXEC, RESP}
  - a helper to test whether an opcode produces a carry
- One sub-module `alu_arb_pick`: a combinational one-hot picker from `req_valid`, `last` and `en`. It compiles to a priority encoder without `ALU_ARB_RR_EN`.

## Test plan
- Reset: `rst_n`=0 → `req_ready`=0, `rsp_valid`=0, all outputs 0. Release with req0 valid, op=4, ra=8'hF0, rb=8'h20 → grant req0; two cycles later `rsp_res`=8'h10, `rsp_car`=1, `rsp_id`=0.
- Round-robin: all three requesters valid continuously, `rsp_ready`=1 → grant order 0, 1, 2, 0, with one grant per 2 cycles. Without `ALU_ARB_RR_EN` → always 0.
- Backpressure: `rsp_ready`=0 for 5 cycles after a response → response fields stable, `req_ready`=0. Release → response drains in the same cycle as the next grant.
- BEQ: op=7, ra=rb=8'h55 → `rsp_branch`=1, `rsp_res`=0, `rsp_zero`=1, `rsp_car`=0. With ra≠rb → `rsp_branch`=0.
- Illegal op: op=12 → `rsp_err`=1, `rsp_res`=0, `rsp_zero`=1. The next op=0 (AND 8'h0F, 8'h3C) → `rsp_res`=8'h0C, `rsp_err`=0.
- Reset mid-EXEC: pulse `rst_n` low → no `rsp_valid`, and the next grant goes to requester 0.
